wb_grf: RTL and testbench
=========================

Name: wb_grf

Overview:
- Write-back stage plus general register file for the 5-stage MIPS pipeline.
- Consumes the W-stage pipeline register outputs (IR_W, PC_W, PC8_W, AO_W, DR_W).
- Decodes the destination register, selects and extends write data, and writes the 32x32 register file on the clock edge.
- Serves the two decode-stage read ports with internal write-before-read bypass, and exposes write info for the hazard/forwarding unit.

Parameters:
- DEBUG_DISPLAY, 1, when 1 emits a simulation-only $display line for every register write with a nonzero destination; no effect on synthesised logic.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- IR_W  input  32  instruction in W stage; 0 means bubble/nop
- PC_W  input  32  PC of the W instruction (debug display only)
- PC8_W  input  32  PC+8 (link value)
- AO_W  input  32  ALU result; also the load address
- DR_W  input  32  raw aligned word read from data memory
- A1  input  5  read address 1 (rs from D stage)
- A2  input  5  read address 2 (rt from D stage)
- RD1  output  32  read data 1
- RD2  output  32  read data 2
- WE_W  output  1  W-stage register write enable (combinational)
- WA_W  output  5  W-stage destination register (combinational)
- WD_W  output  32  W-stage write data (combinational)
- retire_cnt  output  CNT_WIDTH  count of retired non-bubble instructions

Behaviour:
- Reset (sync, active-high): all 32 registers <= 0 and retire_cnt <= 0. Reset wins over a same-cycle write. There is no other reset state. RD*/W* outputs are combinational from their inputs.
- Decode, with op = IR_W[31:26], fn = IR_W[5:0]:
  - R-type (op 0): fn 0x21 addu, 0x23 subu, 0x2a slt, 0x00 sll write rd with AO_W. fn 0x09 jalr writes rd with PC8_W. fn 0x08 jr does not write.
  - I-type ALU: ori 0x0d, lui 0x0f, addiu 0x09 write rt with AO_W.
  - Loads write rt: lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25.
  - jal 0x03 writes $31 with PC8_W.
  - sw 0x2b, beq 0x04, j 0x02 and all unlisted opcodes: WE_W=0, WA_W=0, WD_W=0.
- WE_W = 1 only when the instruction writes and WA_W != 0. A write to $0 forces WE_W=0.
- Load extension:
  - Byte offset b = AO_W[1:0]; the selected byte is DR_W[8b+7:8b].
  - lb sign-extends the byte; lbu zero-extends it.
  - Half select is AO_W[1]: 0 -> DR_W[15:0], 1 -> DR_W[31:16]. lh sign-extends, lhu zero-extends.
  - AO_W[0] is ignored for halfwords, and alignment for lw is ignored. Alignment is guaranteed upstream.
- Write: at posedge clk, when !reset and WE_W, reg[WA_W] <= WD_W. reg[0] always reads 0.
- Read, combinational, for each port i:
  - Ai == 0 -> 0.
  - else if WE_W && WA_W == Ai -> WD_W (internal bypass: same-cycle write is visible).
  - else reg[Ai].
- retire_cnt: at posedge, when !reset and IR_W != 0, increment by 1 and wrap modulo 2^CNT_WIDTH. Bubbles do not count. Non-writing instructions (sw, beq) do count.
- Debug: when DEBUG_DISPLAY && WE_W && !reset, at posedge print "@%h: $%d <= %h" with PC_W, WA_W, WD_W.
- Simultaneous events: both read ports may equal WA_W and both bypass. A1 == A2 is allowed.

Test Plan:
- Reset: assert reset 1 cycle with IR_W = lw $5 writing 0x1234 -> no write; RD1 for A1=5 reads 0; retire_cnt = 0.
- lw: IR_W=0x8C050000 (lw $5), DR_W=0xDEADBEEF, AO_W=0x10 -> WE_W=1, WA_W=5, WD_W=0xDEADBEEF; with A1=5, RD1 = 0xDEADBEEF both in the same cycle (bypass) and the next cycle.
- Byte/half extension, DR_W=0x80FF7F01:
  - lb, AO_W[1:0]=3 -> 0xFFFFFF80.
  - lbu, offset 3 -> 0x00000080.
  - lb, offset 1 -> 0x0000007F.
  - lh, AO_W[1]=1 -> 0xFFFF80FF.
  - lhu, AO_W[1]=0 -> 0x00007F01.
- jal: IR_W=0x0C000100, PC8_W=0x00003008 -> WA_W=31, $31 = 0x00003008 after the edge.
- $0 and non-writers: addu with rd=0, AO_W=5 -> WE_W=0 and RD1(A1=0)=0. sw and beq -> WE_W=0, registers unchanged, retire_cnt still increments.
- Counter/reset mid-run: 5 nonzero IR_W interleaved with 3 bubbles -> retire_cnt = 5. Then reset for 1 cycle -> retire_cnt = 0 and all registers read 0 on the next cycle.

Source files
------------

// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file. Decodes the W-stage
// instruction, picks and extends the write data, updates the register file,
// and serves two decode-stage read ports with same-cycle write bypass.
module wb_grf #(
    parameter int DEBUG_DISPLAY = 1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          IR_W,
    input  logic [31:0]          PC_W,
    input  logic [31:0]          PC8_W,
    input  logic [31:0]          AO_W,
    input  logic [31:0]          DR_W,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    output logic [31:0]          RD1,
    output logic [31:0]          RD2,
    output logic                 WE_W,
    output logic [4:0]           WA_W,
    output logic [31:0]          WD_W,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        WS_NONE, WS_AO, WS_PC8, WS_LW, WS_LB, WS_LBU, WS_LH, WS_LHU
    } wsel_t;

    logic [5:0]  op, fn;
    logic [4:0]  rt, rd;
    wsel_t       sel;
    logic [4:0]  dst;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] wd_raw;
    logic [31:0] regs [0:31];

    assign op = IR_W[31:26];
    assign fn = IR_W[5:0];
    assign rt = IR_W[20:16];
    assign rd = IR_W[15:11];

    // rs/shamt fields only matter to earlier stages; PC_W feeds the trace only
    logic unused_ok;
    assign unused_ok = ^{IR_W[25:21], IR_W[10:6], PC_W};

    // Decode: which source feeds the register file and which register gets it
    always_comb begin
        sel = WS_NONE;
        dst = 5'd0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h21, 6'h23, 6'h2a, 6'h00: begin sel = WS_AO;  dst = rd; end
                    6'h09:                      begin sel = WS_PC8; dst = rd; end
                    default: ;
                endcase
            end
            6'h0d, 6'h0f, 6'h09: begin sel = WS_AO;  dst = rt; end
            6'h23:               begin sel = WS_LW;  dst = rt; end
            6'h20:               begin sel = WS_LB;  dst = rt; end
            6'h24:               begin sel = WS_LBU; dst = rt; end
            6'h21:               begin sel = WS_LH;  dst = rt; end
            6'h25:               begin sel = WS_LHU; dst = rt; end
            6'h03:               begin sel = WS_PC8; dst = 5'd31; end
            default: ;
        endcase
    end

    // Sub-word extraction; alignment is guaranteed upstream so AO_W[0] is
    // ignored for halfwords
    always_comb begin
        case (AO_W[1:0])
            2'd0:    ld_byte = DR_W[7:0];
            2'd1:    ld_byte = DR_W[15:8];
            2'd2:    ld_byte = DR_W[23:16];
            default: ld_byte = DR_W[31:24];
        endcase
        ld_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];
    end

    // Write data mux and write-port outputs; $0 never gets a write enable
    always_comb begin
        case (sel)
            WS_AO:   wd_raw = AO_W;
            WS_PC8:  wd_raw = PC8_W;
            WS_LW:   wd_raw = DR_W;
            WS_LB:   wd_raw = {{24{ld_byte[7]}}, ld_byte};
            WS_LBU:  wd_raw = {24'd0, ld_byte};
            WS_LH:   wd_raw = {{16{ld_half[15]}}, ld_half};
            WS_LHU:  wd_raw = {16'd0, ld_half};
            default: wd_raw = 32'd0;
        endcase
        WE_W = (sel != WS_NONE) && (dst != 5'd0);
        WA_W = (sel != WS_NONE) ? dst : 5'd0;
        WD_W = wd_raw;
    end

    // Read ports with write-before-read bypass so D sees this cycle's result
    always_comb begin
        if (A1 == 5'd0)                RD1 = 32'd0;
        else if (WE_W && WA_W == A1)   RD1 = WD_W;
        else                           RD1 = regs[A1];
        if (A2 == 5'd0)                RD2 = 32'd0;
        else if (WE_W && WA_W == A2)   RD2 = WD_W;
        else                           RD2 = regs[A2];
    end

    // Register file update; reset takes priority over a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (WE_W) begin
            regs[WA_W] <= WD_W;
        end
    end

    // Retired-instruction counter; bubbles (IR_W == 0) do not count
    always_ff @(posedge clk) begin
        if (reset)              retire_cnt <= '0;
        else if (IR_W != 32'd0) retire_cnt <= retire_cnt + 1'b1;
    end

`ifndef SYNTHESIS
    generate
        if (DEBUG_DISPLAY != 0) begin : g_trace
            // Simulation-only trace of every architectural register write
            always_ff @(posedge clk) begin
                if (WE_W && !reset) $display("@%h: $%d <= %h", PC_W, WA_W, WD_W);
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: reset, loads with extension, links, non-writers,
// bypass on both ports, and the retire counter across a mid-run reset.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_W, PC_W, PC8_W, AO_W, DR_W;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, WD_W;
    logic        WE_W;
    logic [4:0]  WA_W;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    wb_grf #(.DEBUG_DISPLAY(0), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC_W(PC_W), .PC8_W(PC8_W),
        .AO_W(AO_W), .DR_W(DR_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WE_W(WE_W), .WA_W(WA_W), .WD_W(WD_W), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; IR_W = 32'h8C050000; DR_W = 32'h00001234; AO_W = 32'h0;
        PC_W = 32'h0; PC8_W = 32'h0; A1 = 5'd5; A2 = 5'd0;
        tick();
        reset = 1'b0; IR_W = 32'h0; #1;
        checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", RD1, 32'h0); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", retire_cnt); end
    endtask

    task automatic test_lw();
        IR_W = 32'h8C050000; DR_W = 32'hDEADBEEF; AO_W = 32'h10; A1 = 5'd5; A2 = 5'd0; #1;
        checks++; if (WE_W !== 1'b1) begin errors++; $display("FAIL lw_we got %b exp 1", WE_W); end
        checks++; if (WA_W !== 5'd5) begin errors++; $display("FAIL lw_wa got %0d exp 5", WA_W); end
        checks++; if (WD_W !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wd got %h exp deadbeef", WD_W); end
        checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_bypass got %h exp deadbeef", RD1); end
        tick();
        IR_W = 32'h0; #1;
        checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_stored got %h exp deadbeef", RD1); end
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL lw_cnt got %0d exp 1", retire_cnt); end
    endtask

    task automatic test_extension();
        logic [31:0] ir [5];
        logic [31:0] ao [5];
        logic [31:0] exp [5];
        ir[0] = 32'h80060000; ao[0] = 32'h3; exp[0] = 32'hFFFFFF80; // lb  $6, off 3
        ir[1] = 32'h90070000; ao[1] = 32'h3; exp[1] = 32'h00000080; // lbu $7, off 3
        ir[2] = 32'h80060000; ao[2] = 32'h1; exp[2] = 32'h0000007F; // lb  $6, off 1
        ir[3] = 32'h84080000; ao[3] = 32'h2; exp[3] = 32'hFFFF80FF; // lh  $8, upper
        ir[4] = 32'h94090000; ao[4] = 32'h0; exp[4] = 32'h00007F01; // lhu $9, lower
        DR_W = 32'h80FF7F01;
        for (int i = 0; i < 5; i++) begin
            IR_W = ir[i]; AO_W = ao[i]; A1 = IR_W[20:16]; A2 = IR_W[20:16]; #1;
            checks++; if (WD_W !== exp[i]) begin errors++; $display("FAIL ext_wd[%0d] got %h exp %h", i, WD_W, exp[i]); end
            checks++; if (RD1 !== exp[i] || RD2 !== exp[i]) begin errors++; $display("FAIL ext_bypass2[%0d] got %h/%h exp %h", i, RD1, RD2, exp[i]); end
            tick();
        end
        IR_W = 32'h0; A1 = 5'd6; A2 = 5'd8; #1;
        checks++; if (RD1 !== 32'h0000007F) begin errors++; $display("FAIL ext_r6 got %h exp 0000007f", RD1); end
        checks++; if (RD2 !== 32'hFFFF80FF) begin errors++; $display("FAIL ext_r8 got %h exp ffff80ff", RD2); end
        A1 = 5'd7; A2 = 5'd9; #1;
        checks++; if (RD1 !== 32'h00000080) begin errors++; $display("FAIL ext_r7 got %h exp 00000080", RD1); end
        checks++; if (RD2 !== 32'h00007F01) begin errors++; $display("FAIL ext_r9 got %h exp 00007f01", RD2); end
        checks++; if (retire_cnt !== 32'd6) begin errors++; $display("FAIL ext_cnt got %0d exp 6", retire_cnt); end
    endtask

    task automatic test_link();
        IR_W = 32'h0C000100; PC8_W = 32'h00003008; AO_W = 32'h0; A1 = 5'd31; A2 = 5'd0; #1;
        checks++; if (WA_W !== 5'd31 || WE_W !== 1'b1) begin errors++; $display("FAIL jal_wa got %0d/%b exp 31/1", WA_W, WE_W); end
        tick();
        IR_W = 32'h00206009; PC8_W = 32'h00004008; A2 = 5'd12; #1;  // jalr $12
        checks++; if (RD1 !== 32'h00003008) begin errors++; $display("FAIL jal_r31 got %h exp 00003008", RD1); end
        checks++; if (WA_W !== 5'd12 || WD_W !== 32'h00004008) begin errors++; $display("FAIL jalr_w got %0d/%h exp 12/00004008", WA_W, WD_W); end
        tick();
        IR_W = 32'h00200008; #1;                                      // jr: no write
        checks++; if (WE_W !== 1'b0 || RD2 !== 32'h00004008) begin errors++; $display("FAIL jr_nowrite got %b/%h exp 0/00004008", WE_W, RD2); end
        tick();
    endtask

    task automatic test_nowrite();
        IR_W = 32'h00220021; AO_W = 32'h5; A1 = 5'd0; A2 = 5'd5; #1;   // addu $0
        checks++; if (WE_W !== 1'b0) begin errors++; $display("FAIL r0_we got %b exp 0", WE_W); end
        checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL r0_rd got %h exp 0", RD1); end
        tick();
        IR_W = 32'hAC050000; AO_W = 32'h10; #1;                        // sw $5
        checks++; if (WE_W !== 1'b0 || WA_W !== 5'd0 || WD_W !== 32'h0) begin errors++; $display("FAIL sw_w got %b/%0d/%h exp 0/0/0", WE_W, WA_W, WD_W); end
        tick();
        IR_W = 32'h10000000; #1;                                       // beq
        checks++; if (WE_W !== 1'b0) begin errors++; $display("FAIL beq_we got %b exp 0", WE_W); end
        tick();
        IR_W = 32'h0; #1;
        checks++; if (RD2 !== 32'hDEADBEEF) begin errors++; $display("FAIL nowrite_r5 got %h exp deadbeef", RD2); end
        checks++; if (retire_cnt !== 32'd12) begin errors++; $display("FAIL nowrite_cnt got %0d exp 12", retire_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [8];
        logic [31:0] ao  [8];
        reset = 1'b1; IR_W = 32'h0; tick(); reset = 1'b0;
        seq[0] = 32'h34030000; ao[0] = 32'h55;  // ori  $3
        seq[1] = 32'h0;        ao[1] = 32'h0;
        seq[2] = 32'h00225021; ao[2] = 32'h77;  // addu $10
        seq[3] = 32'h0;        ao[3] = 32'h0;
        seq[4] = 32'hAC050000; ao[4] = 32'h10;  // sw
        seq[5] = 32'h0;        ao[5] = 32'h0;
        seq[6] = 32'h10000000; ao[6] = 32'h0;   // beq
        seq[7] = 32'h3C0A0000; ao[7] = 32'h99;  // lui  $10 overwrites back-to-back
        for (int i = 0; i < 8; i++) begin
            IR_W = seq[i]; AO_W = ao[i]; tick();
        end
        IR_W = 32'h0; A1 = 5'd3; A2 = 5'd10; #1;
        checks++; if (retire_cnt !== 32'd5) begin errors++; $display("FAIL cnt5 got %0d exp 5", retire_cnt); end
        checks++; if (RD1 !== 32'h55 || RD2 !== 32'h99) begin errors++; $display("FAIL b2b_regs got %h/%h exp 55/99", RD1, RD2); end
        reset = 1'b1; tick(); reset = 1'b0; #1;
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", retire_cnt); end
        checks++; if (RD1 !== 32'h0 || RD2 !== 32'h0) begin errors++; $display("FAIL rst_regs got %h/%h exp 0/0", RD1, RD2); end
        A1 = 5'd31; A2 = 5'd5; #1;
        checks++; if (RD1 !== 32'h0 || RD2 !== 32'h0) begin errors++; $display("FAIL rst_regs2 got %h/%h exp 0/0", RD1, RD2); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_extension();
        test_link();
        test_nowrite();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
